// File: rtl/cpu_types_pkg.sv
// Shared CPU/RAM types: word, RAM status, and the arbiter's source and state encodings.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      DWR = 2'd0,
      DRD = 2'd1,
      IRD = 2'd2
   } arb_src_t;

   typedef enum logic {
      IDLE  = 1'b0,
      SERVE = 1'b1
   } arb_state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Cache-side request ports and the shared RAM port seen by ram_arbiter.
interface ram_arbiter_if
   import cpu_types_pkg::*;
#(
   parameter int unsigned CPUS = 2
);
   logic [CPUS-1:0]    iREN;
   logic [CPUS-1:0]    dREN;
   logic [CPUS-1:0]    dWEN;
   logic [CPUS*32-1:0] iaddr;
   logic [CPUS*32-1:0] daddr;
   logic [CPUS*32-1:0] dstore;
   logic [CPUS-1:0]    iwait;
   logic [CPUS-1:0]    dwait;
   logic [CPUS*32-1:0] iload;
   logic [CPUS*32-1:0] dload;
   ramstate_t          ramstate;
   word_t              ramload;
   logic               ramREN;
   logic               ramWEN;
   word_t              ramaddr;
   word_t              ramstore;

   modport slave (
      input  iREN, dREN, dWEN, iaddr, daddr, dstore, ramstate, ramload,
      output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
   );

   modport master (
      output iREN, dREN, dWEN, iaddr, daddr, dstore, ramstate, ramload,
      input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
   );
endinterface

// File: rtl/ram_arbiter_rr_picker.sv
// Round-robin picker: first requesting index at or after rr_ptr, wrapping modulo CPUS.
module rr_picker #(
   parameter int unsigned CPUS = 2,
   parameter int unsigned IW   = 1
) (
   input  logic [CPUS-1:0] req,
   input  logic [IW-1:0]   rr_ptr,
   output logic            valid,
   output logic [IW-1:0]   idx
);

   int unsigned pos;

   always_comb begin
      valid = 1'b0;
      idx   = '0;
      pos   = 0;
      for (int unsigned k = 0; k < CPUS; k++) begin
         pos = (int'(rr_ptr) + k) % CPUS;
         if (!valid && req[pos]) begin
            valid = 1'b1;
            idx   = IW'(pos);
         end
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Multi-core RAM arbiter: round-robin across cores, data before instruction within a core,
// grant held until ACCESS, timeout or withdrawal.
module ram_arbiter
   import cpu_types_pkg::*;
#(
   parameter int unsigned CPUS    = 2,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic          CLK,
   input  logic          RST,
   ram_arbiter_if.slave  bus,
   output logic          timeout_err
);

   localparam int unsigned IW = (CPUS > 1) ? $clog2(CPUS) : 1;

   arb_state_t      state_q, state_d;
   arb_src_t        grant_src_q, grant_src_d;
   logic [IW-1:0]   grant_cpu_q, grant_cpu_d;
   logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [7:0]      tcount_q, tcount_d;
   logic            timeout_err_q, timeout_err_d;

   logic            pick_valid;
   logic [IW-1:0]   pick_idx;
   logic [IW-1:0]   rr_next;
   logic            live;
   word_t           g_iaddr, g_daddr, g_dstore;

   rr_picker #(.CPUS(CPUS), .IW(IW)) u_picker (
      .req    (bus.iREN | bus.dREN | bus.dWEN),
      .rr_ptr (rr_ptr_q),
      .valid  (pick_valid),
      .idx    (pick_idx)
   );

   assign bus.iload   = {CPUS{bus.ramload}};
   assign bus.dload   = {CPUS{bus.ramload}};
   assign timeout_err = timeout_err_q;
   assign rr_next     = (grant_cpu_q == IW'(CPUS - 1)) ? '0 : grant_cpu_q + IW'(1);
   assign g_iaddr     = bus.iaddr[32*int'(grant_cpu_q) +: 32];
   assign g_daddr     = bus.daddr[32*int'(grant_cpu_q) +: 32];
   assign g_dstore    = bus.dstore[32*int'(grant_cpu_q) +: 32];

   // The lock follows the live request bit so a withdrawn request stops hitting RAM at once.
   always_comb begin
      case (grant_src_q)
         DWR:     live = bus.dWEN[grant_cpu_q];
         DRD:     live = bus.dREN[grant_cpu_q];
         default: live = bus.iREN[grant_cpu_q];
      endcase
   end

   always_comb begin
      state_d       = state_q;
      grant_src_d   = grant_src_q;
      grant_cpu_d   = grant_cpu_q;
      rr_ptr_d      = rr_ptr_q;
      tcount_d      = tcount_q;
      timeout_err_d = 1'b0;
      bus.iwait     = '1;
      bus.dwait     = '1;
      bus.ramREN    = 1'b0;
      bus.ramWEN    = 1'b0;
      bus.ramaddr   = '0;
      bus.ramstore  = '0;

      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               grant_cpu_d = pick_idx;
               if (bus.dWEN[pick_idx])      grant_src_d = DWR;
               else if (bus.dREN[pick_idx]) grant_src_d = DRD;
               else                         grant_src_d = IRD;
               tcount_d = '0;
               state_d  = SERVE;
            end
         end

         default: begin
            case (grant_src_q)
               DWR: begin
                  bus.ramWEN   = live;
                  bus.ramaddr  = g_daddr;
                  bus.ramstore = g_dstore;
               end
               DRD: begin
                  bus.ramREN  = live;
                  bus.ramaddr = g_daddr;
               end
               default: begin
                  bus.ramREN  = live;
                  bus.ramaddr = g_iaddr;
               end
            endcase

            // Priority order: withdrawal, then ACCESS, then timeout.
            if (!live) begin
               state_d = IDLE;
            end else if (bus.ramstate == ACCESS) begin
               if (grant_src_q == IRD) bus.iwait[grant_cpu_q] = 1'b0;
               else                    bus.dwait[grant_cpu_q] = 1'b0;
               rr_ptr_d = rr_next;
               state_d  = IDLE;
            end else if (tcount_q >= 8'(TIMEOUT - 1)) begin
               timeout_err_d = 1'b1;
               rr_ptr_d      = rr_next;
               state_d       = IDLE;
            end else if (tcount_q != '1) begin
               tcount_d = tcount_q + 8'd1;
            end
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q       <= IDLE;
         grant_src_q   <= DWR;
         grant_cpu_q   <= '0;
         rr_ptr_q      <= '0;
         tcount_q      <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_src_q   <= grant_src_d;
         grant_cpu_q   <= grant_cpu_d;
         rr_ptr_q      <= rr_ptr_d;
         tcount_q      <= tcount_d;
         timeout_err_q <= timeout_err_d;
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with CPUS=2, TIMEOUT=64.
module tb_ram_arbiter;
   import cpu_types_pkg::*;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic timeout_err;
   int   n_checks = 0;
   int   n_pass   = 0;

   ram_arbiter_if #(.CPUS(2)) bus ();

   ram_arbiter #(.CPUS(2), .TIMEOUT(64)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .bus         (bus.slave),
      .timeout_err (timeout_err)
   );

   always #5 CLK = ~CLK;

   // Registered state updates at posedge; inputs change 2 time units later, checks 1 unit after that.
   task automatic step();
      @(posedge CLK);
      #2;
   endtask

   task automatic clear_inputs();
      bus.iREN = '0; bus.dREN = '0; bus.dWEN = '0;
      bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
      bus.ramstate = FREE; bus.ramload = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      RST = 1'b1;
      step();
      RST = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_checks++;
      if ({bus.iwait, bus.dwait} !== 4'b1111) $display("FAIL reset_waits got %b expected 1111", {bus.iwait, bus.dwait});
      else n_pass++;
      n_checks++;
      if ({bus.ramREN, bus.ramWEN, timeout_err} !== 3'b000) $display("FAIL reset_enables got %b expected 000", {bus.ramREN, bus.ramWEN, timeout_err});
      else n_pass++;
      n_checks++;
      if ({bus.ramaddr, bus.ramstore} !== 64'h0) $display("FAIL reset_bus got %h expected 0", {bus.ramaddr, bus.ramstore});
      else n_pass++;
      n_checks++;
      if (dut.state_q !== IDLE || dut.rr_ptr_q !== 1'b0) $display("FAIL reset_state got %b/%b expected 0/0", dut.state_q, dut.rr_ptr_q);
      else n_pass++;
   endtask

   task automatic test_single_read();
      do_reset();
      bus.dREN = 2'b01; bus.daddr = {32'h0000_0999, 32'h0000_0100}; bus.ramstate = BUSY;
      #1;
      n_checks++;
      if (bus.ramREN !== 1'b0) $display("FAIL read_arb_cycle ramREN got %b expected 0", bus.ramREN);
      else n_pass++;
      step(); #1;
      n_checks++;
      if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h100 || bus.dwait !== 2'b11)
         $display("FAIL read_first got ren=%b addr=%h dwait=%b expected 1/100/11", bus.ramREN, bus.ramaddr, bus.dwait);
      else n_pass++;
      step();
      bus.ramstate = ACCESS; bus.ramload = 32'hDEAD_BEEF;
      #1;
      n_checks++;
      if (bus.ramREN !== 1'b1 || bus.dwait !== 2'b10 || bus.iwait !== 2'b11)
         $display("FAIL read_access got ren=%b dwait=%b iwait=%b expected 1/10/11", bus.ramREN, bus.dwait, bus.iwait);
      else n_pass++;
      n_checks++;
      if (bus.dload[31:0] !== 32'hDEAD_BEEF) $display("FAIL read_dload got %h expected deadbeef", bus.dload[31:0]);
      else n_pass++;
      step();
      bus.dREN = '0; bus.ramstate = FREE;
      #1;
      n_checks++;
      if (dut.state_q !== IDLE || bus.ramREN !== 1'b0 || bus.dwait !== 2'b11 || dut.rr_ptr_q !== 1'b1)
         $display("FAIL read_done got st=%b ren=%b dwait=%b rr=%b expected 0/0/11/1", dut.state_q, bus.ramREN, bus.dwait, dut.rr_ptr_q);
      else n_pass++;
   endtask

   task automatic test_contention();
      logic [31:0] exp_addr [3];
      logic [1:0]  exp_dwait [3];
      exp_addr  = '{32'h200, 32'h300, 32'h200};
      exp_dwait = '{2'b10, 2'b01, 2'b10};
      do_reset();
      bus.dREN = 2'b11; bus.daddr = {32'h0000_0300, 32'h0000_0200};
      for (int i = 0; i < 3; i++) begin
         step();
         bus.ramstate = ACCESS;
         #1;
         n_checks++;
         if (bus.ramaddr !== exp_addr[i] || bus.dwait !== exp_dwait[i] || bus.ramREN !== 1'b1)
            $display("FAIL contention_grant%0d got addr=%h dwait=%b ren=%b expected %h/%b/1", i, bus.ramaddr, bus.dwait, bus.ramREN, exp_addr[i], exp_dwait[i]);
         else n_pass++;
         step();
         bus.ramstate = FREE;
         #1;
         n_checks++;
         if (bus.ramREN !== 1'b0 || bus.dwait !== 2'b11)
            $display("FAIL contention_idle%0d got ren=%b dwait=%b expected 0/11", i, bus.ramREN, bus.dwait);
         else n_pass++;
      end
      bus.dREN = '0;
   endtask

   task automatic test_priority();
      do_reset();
      bus.iREN = 2'b10; bus.dWEN = 2'b10;
      bus.daddr  = {32'h0000_0040, 32'h0};
      bus.dstore = {32'h1234_5678, 32'h0};
      bus.iaddr  = {32'h0000_0080, 32'h0};
      step(); #1;
      n_checks++;
      if (bus.ramWEN !== 1'b1 || bus.ramREN !== 1'b0 || bus.ramaddr !== 32'h40 || bus.ramstore !== 32'h1234_5678)
         $display("FAIL prio_write got wen=%b ren=%b addr=%h store=%h expected 1/0/40/12345678", bus.ramWEN, bus.ramREN, bus.ramaddr, bus.ramstore);
      else n_pass++;
      bus.ramstate = ACCESS;
      #1;
      n_checks++;
      if (bus.dwait !== 2'b01 || bus.iwait !== 2'b11)
         $display("FAIL prio_write_ack got dwait=%b iwait=%b expected 01/11", bus.dwait, bus.iwait);
      else n_pass++;
      step();
      bus.dWEN = '0; bus.ramstate = FREE;
      step(); #1;
      n_checks++;
      if (bus.ramREN !== 1'b1 || bus.ramWEN !== 1'b0 || bus.ramaddr !== 32'h80)
         $display("FAIL prio_iread got ren=%b wen=%b addr=%h expected 1/0/80", bus.ramREN, bus.ramWEN, bus.ramaddr);
      else n_pass++;
      bus.ramstate = ACCESS;
      #1;
      n_checks++;
      if (bus.iwait !== 2'b01 || bus.dwait !== 2'b11)
         $display("FAIL prio_iread_ack got iwait=%b dwait=%b expected 01/11", bus.iwait, bus.dwait);
      else n_pass++;
      step();
      bus.iREN = '0; bus.ramstate = FREE;
   endtask

   task automatic test_timeout();
      int bad;
      do_reset();
      bus.iREN = 2'b01; bus.iaddr = {32'h0, 32'h0000_0500}; bus.ramstate = BUSY;
      bad = 0;
      for (int i = 0; i < 64; i++) begin
         step(); #1;
         if (bus.ramREN !== 1'b1 || bus.iwait !== 2'b11 || timeout_err !== 1'b0) bad++;
      end
      n_checks++;
      if (bad !== 0) $display("FAIL timeout_hold got %0d bad cycles expected 0", bad);
      else n_pass++;
      step();
      bus.iREN = '0;
      #1;
      n_checks++;
      if (timeout_err !== 1'b1 || dut.state_q !== IDLE || dut.rr_ptr_q !== 1'b1 || bus.iwait !== 2'b11)
         $display("FAIL timeout_abort got err=%b st=%b rr=%b iwait=%b expected 1/0/1/11", timeout_err, dut.state_q, dut.rr_ptr_q, bus.iwait);
      else n_pass++;
      step(); #1;
      n_checks++;
      if (timeout_err !== 1'b0) $display("FAIL timeout_pulse_len got %b expected 0", timeout_err);
      else n_pass++;
      bus.ramstate = FREE;
   endtask

   task automatic test_withdraw();
      do_reset();
      bus.dREN = 2'b01; bus.daddr = {32'h0, 32'h0000_0600}; bus.ramstate = BUSY;
      step(); step(); #1;
      n_checks++;
      if (bus.ramREN !== 1'b1) $display("FAIL withdraw_pre got ren=%b expected 1", bus.ramREN);
      else n_pass++;
      bus.dREN = '0; bus.ramstate = ACCESS;
      #1;
      n_checks++;
      if (bus.ramREN !== 1'b0 || bus.dwait !== 2'b11)
         $display("FAIL withdraw_drop got ren=%b dwait=%b expected 0/11", bus.ramREN, bus.dwait);
      else n_pass++;
      step();
      bus.ramstate = FREE;
      #1;
      n_checks++;
      if (dut.state_q !== IDLE || dut.rr_ptr_q !== 1'b0 || bus.dwait !== 2'b11)
         $display("FAIL withdraw_idle got st=%b rr=%b dwait=%b expected 0/0/11", dut.state_q, dut.rr_ptr_q, bus.dwait);
      else n_pass++;
   endtask

   task automatic test_reset_mid_serve();
      do_reset();
      bus.dWEN = 2'b01; bus.daddr = {32'h0, 32'h0000_0700}; bus.dstore = {32'h0, 32'hAAAA_5555}; bus.ramstate = BUSY;
      step(); #1;
      n_checks++;
      if (bus.ramWEN !== 1'b1 || bus.ramstore !== 32'hAAAA_5555)
         $display("FAIL rst_mid_pre got wen=%b store=%h expected 1/aaaa5555", bus.ramWEN, bus.ramstore);
      else n_pass++;
      RST = 1'b1;
      step(); #1;
      n_checks++;
      if (dut.state_q !== IDLE || bus.ramWEN !== 1'b0 || bus.ramaddr !== 32'h0 || bus.ramstore !== 32'h0 || bus.dwait !== 2'b11 || timeout_err !== 1'b0)
         $display("FAIL rst_mid_post got st=%b wen=%b addr=%h store=%h dwait=%b err=%b expected reset values",
                  dut.state_q, bus.ramWEN, bus.ramaddr, bus.ramstore, bus.dwait, timeout_err);
      else n_pass++;
      RST = 1'b0;
      bus.dWEN = '0;
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_single_read();
      test_contention();
      test_priority();
      test_timeout();
      test_withdraw();
      test_reset_mid_serve();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
